// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: CPU core (port A) and
// debug/program-loader (port B) request, grant and completion signals.
interface data_mem_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [15:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_gnt;
  logic        a_done;
  logic [15:0] a_rdata;
  logic        a_err;

  logic        b_req;
  logic        b_we;
  logic [15:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_gnt;
  logic        b_done;
  logic [15:0] b_rdata;
  logic        b_err;
  logic        b_lock;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_done, a_rdata, a_err,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    input  b_gnt, b_done, b_rdata, b_err
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_done, a_rdata, a_err,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    output b_gnt, b_done, b_rdata, b_err
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory wrapper,
// with starvation protection and a burst lock for port B.
module data_mem_arbiter #(
  parameter int unsigned MAX_WAIT   = 4,
  parameter logic [15:0] ADDR_LIMIT = 16'h0200
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_arbiter_if.slave bus,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_we,
  input  logic [15:0]       mem_q
);

  typedef enum logic {ARB, LOCK_B} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_t      state;
  logic [3:0]  wait_cnt;

  logic        iss_valid;
  port_t       iss_port;
  logic        iss_we;
  logic        iss_err;

  logic        a_gnt;
  logic        b_gnt;
  logic        gnt_any;
  port_t       gnt_port;
  logic        gnt_we;
  logic [15:0] gnt_addr;
  logic [15:0] gnt_wdata;
  logic        gnt_err;
  logic [15:0] ret_data;

  logic        a_done_q;
  logic        b_done_q;
  logic        a_err_q;
  logic        b_err_q;
  logic [15:0] a_rdata_q;
  logic [15:0] b_rdata_q;

  // Grants are forced low while reset is asserted so no request leaks through.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (state == LOCK_B) begin
        b_gnt = bus.b_req;
      end else if (bus.a_req && !(bus.b_req && (wait_cnt >= WAIT_LIMIT))) begin
        a_gnt = 1'b1;
      end else begin
        b_gnt = bus.b_req;
      end
    end
  end

  always_comb begin
    gnt_any   = a_gnt | b_gnt;
    gnt_port  = PORT_A;
    gnt_we    = bus.a_we;
    gnt_addr  = bus.a_addr;
    gnt_wdata = bus.a_wdata;
    if (b_gnt) begin
      gnt_port  = PORT_B;
      gnt_we    = bus.b_we;
      gnt_addr  = bus.b_addr;
      gnt_wdata = bus.b_wdata;
    end
    gnt_err = (gnt_addr >= ADDR_LIMIT);
  end

  assign ret_data = (iss_valid && !iss_we && !iss_err) ? mem_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB;
      wait_cnt  <= '0;
      iss_valid <= 1'b0;
      iss_port  <= PORT_A;
      iss_we    <= 1'b0;
      iss_err   <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      case (state)
        ARB:    if (b_gnt && bus.b_lock) state <= LOCK_B;
        LOCK_B: if (!bus.b_lock)         state <= ARB;
        default:                         state <= ARB;
      endcase

      if (!bus.b_req || b_gnt) begin
        wait_cnt <= '0;
      end else if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      // Issue stage: address/data hold their last value when idle.
      iss_valid <= gnt_any;
      if (gnt_any) begin
        iss_port <= gnt_port;
        iss_we   <= gnt_we;
        iss_err  <= gnt_err;
        mem_addr <= gnt_addr;
        mem_data <= gnt_wdata;
        mem_we   <= gnt_we & ~gnt_err;
      end else begin
        mem_we   <= 1'b0;
      end

      // Completion stage: one pulse to the port that owned the issue slot.
      a_done_q  <= iss_valid && (iss_port == PORT_A);
      b_done_q  <= iss_valid && (iss_port == PORT_B);
      a_err_q   <= iss_valid && (iss_port == PORT_A) && iss_err;
      b_err_q   <= iss_valid && (iss_port == PORT_B) && iss_err;
      a_rdata_q <= (iss_port == PORT_A) ? ret_data : '0;
      b_rdata_q <= (iss_port == PORT_B) ? ret_data : '0;
    end
  end

  assign bus.a_gnt   = a_gnt;
  assign bus.b_gnt   = b_gnt;
  assign bus.a_done  = a_done_q;
  assign bus.b_done  = b_done_q;
  assign bus.a_err   = a_err_q;
  assign bus.b_err   = b_err_q;
  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter against a small word-addressed memory
// model that writes on the falling edge and reads asynchronously.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic [15:0] mem_q;

  logic [15:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [15:0] pre_dat = '0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  data_mem_arbiter_if bus ();

  data_mem_arbiter #(
    .MAX_WAIT   (4),
    .ADDR_LIMIT (16'h0200)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .mem_q    (mem_q)
  );

  always #5 clk = ~clk;

  assign mem_q = mem[mem_addr[8:1]];

  always @(negedge clk) begin
    if (mem_we)      mem[mem_addr[8:1]] <= mem_data;
    else if (pre_we) mem[pre_idx]       <= pre_dat;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [15:0] dat);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_dat = dat;
    @(negedge clk);
    #1 pre_we = 1'b0;
    tick();
  endtask

  task automatic a_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    bus.a_req  = 1'b1;
    bus.a_we   = 1'b0;
    bus.a_addr = addr;
    @(negedge clk);
    check({tag, "_gnt"}, 16'(bus.a_gnt), 16'd1);
    tick();
    bus.a_req = 1'b0;
    tick();
    check({tag, "_done"},  16'(bus.a_done), 16'd1);
    check({tag, "_rdata"}, bus.a_rdata, exp);
    check({tag, "_err"},   16'(bus.a_err), 16'd0);
  endtask

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.b_lock = 1'b0;

    // Reset state, with a request present to show grants are masked
    tick();
    tick();
    bus.a_req = 1'b1;
    @(negedge clk);
    check("rst_a_gnt",   16'(bus.a_gnt),  16'd0);
    check("rst_a_done",  16'(bus.a_done), 16'd0);
    check("rst_b_done",  16'(bus.b_done), 16'd0);
    check("rst_mem_we",  16'(mem_we),     16'd0);
    check("rst_mem_addr", mem_addr,       16'h0000);
    check("rst_a_rdata", bus.a_rdata,     16'h0000);
    tick();
    bus.a_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single read on port A: done two edges after grant
    preload(8'h08, 16'h1234);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0010;
    @(negedge clk);
    check("rd_a_gnt", 16'(bus.a_gnt), 16'd1);
    check("rd_b_gnt", 16'(bus.b_gnt), 16'd0);
    tick();
    bus.a_req = 1'b0;
    @(negedge clk);
    check("rd_early_done", 16'(bus.a_done), 16'd0);
    check("rd_mem_addr",   mem_addr,        16'h0010);
    check("rd_mem_we",     16'(mem_we),     16'd0);
    tick();
    check("rd_a_done",  16'(bus.a_done), 16'd1);
    check("rd_a_rdata", bus.a_rdata,     16'h1234);
    check("rd_b_done",  16'(bus.b_done), 16'd0);
    tick();
    check("rd_done_pulse", 16'(bus.a_done), 16'd0);

    // Contention: B forced in every 5th cycle
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0100;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 16'h0102;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("cont_a_gnt%0d", i), 16'(bus.a_gnt), (i % 5 == 4) ? 16'd0 : 16'd1);
      check($sformatf("cont_b_gnt%0d", i), 16'(bus.b_gnt), (i % 5 == 4) ? 16'd1 : 16'd0);
      tick();
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick();
    tick();
    tick();

    // Lock burst: four port-B writes, port A locked out
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_wdata = 16'hA0A0; bus.b_lock = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.b_addr = 16'h0020 + 16'(2 * k);
      @(negedge clk);
      check($sformatf("lock_b_gnt%0d", k), 16'(bus.b_gnt), 16'd1);
      check($sformatf("lock_a_gnt%0d", k), 16'(bus.a_gnt), 16'd0);
      tick();
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0100;
    end
    bus.b_req = 1'b0; bus.b_lock = 1'b0; bus.b_we = 1'b0;
    @(negedge clk);
    check("lock_tail_a_gnt", 16'(bus.a_gnt), 16'd0);
    tick();
    bus.a_req = 1'b0;
    tick();
    tick();
    a_read("lock_rb0", 16'h0020, 16'hA0A0);
    a_read("lock_rb3", 16'h0026, 16'hA0A0);

    // Out-of-range write on port B
    preload(8'h00, 16'hBEEF);
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h0200; bus.b_wdata = 16'h1111;
    @(negedge clk);
    check("oor_b_gnt", 16'(bus.b_gnt), 16'd1);
    tick();
    bus.b_req = 1'b0; bus.b_we = 1'b0;
    @(negedge clk);
    check("oor_mem_we", 16'(mem_we), 16'd0);
    tick();
    check("oor_b_done",  16'(bus.b_done), 16'd1);
    check("oor_b_err",   16'(bus.b_err),  16'd1);
    check("oor_b_rdata", bus.b_rdata,     16'h0000);
    a_read("oor_rb0", 16'h0000, 16'hBEEF);

    // Back-to-back write then read of the same word
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 16'h0030; bus.a_wdata = 16'h5555;
    @(negedge clk);
    check("b2b_wr_gnt", 16'(bus.a_gnt), 16'd1);
    tick();
    bus.a_we = 1'b0;
    @(negedge clk);
    check("b2b_rd_gnt",   16'(bus.a_gnt), 16'd1);
    check("b2b_mem_we",   16'(mem_we),    16'd1);
    check("b2b_mem_data", mem_data,       16'h5555);
    tick();
    bus.a_req = 1'b0;
    check("b2b_wr_done",  16'(bus.a_done), 16'd1);
    check("b2b_wr_rdata", bus.a_rdata,     16'h0000);
    tick();
    check("b2b_rd_done",  16'(bus.a_done), 16'd1);
    check("b2b_rd_rdata", bus.a_rdata,     16'h5555);
    tick();
    check("b2b_idle_done", 16'(bus.a_done), 16'd0);

    // Reset lands on the edge that would capture a write grant
    preload(8'h20, 16'h7777);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 16'h0040; bus.a_wdata = 16'h9999;
    @(negedge clk);
    check("rst_wr_gnt", 16'(bus.a_gnt), 16'd1);
    #1 rst_n = 1'b0;
    bus.a_req = 1'b0;
    bus.a_we  = 1'b0;
    tick();
    check("mid_mem_we",   16'(mem_we),      16'd0);
    check("mid_mem_addr", mem_addr,         16'h0000);
    check("mid_mem_data", mem_data,         16'h0000);
    check("mid_a_done",   16'(bus.a_done),  16'd0);
    check("mid_a_err",    16'(bus.a_err),   16'd0);
    tick();
    check("mid_a_done2",  16'(bus.a_done),  16'd0);
    check("mid_word",     mem[32],          16'h7777);
    rst_n = 1'b1;
    tick();
    a_read("mid_rb", 16'h0040, 16'h7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
